sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single-port RA1SHD 512x8 SRAM between three requesters: the
//  serial IO controller (IO), CPU data port (D) and CPU instruction fetch (I).
//  Replaces the ad-hoc is_i_addr mux. Drives CEN/WEN/A/D from registers and
//  returns Q with a per-requester valid. Provides an exclusive IO lock mode
//  for scan load/dump while the CPU is stalled.
// PARAMETERS
//  ADDR_WIDTH    9  SRAM address bits
//  DATA_WIDTH    8  SRAM data bits
//  STARVE_LIMIT  8  cycles IO may wait unserved before it is promoted (>=1)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  io_lock      in   1   IO requests exclusive ownership of the SRAM
//  io_lock_ack  out  1   exclusive ownership granted
//  cpu_stall    out  1   CPU must hold its pipeline (lock pending or held)
//  io_req/d_req/i_req          in  1   access request, held until *_gnt
//  io_we/d_we                  in  1   1=write, 0=read (I is read-only)
//  io_addr/d_addr/i_addr       in  ADDR_WIDTH  access address
//  io_wdata/d_wdata            in  DATA_WIDTH  write data
//  io_gnt/d_gnt/i_gnt          out 1   access issued to SRAM this cycle
//  io_rvalid/d_rvalid/i_rvalid out 1   rdata valid for that requester
//  rdata        out  DATA_WIDTH  read data (= sram_q)
//  sram_cen     out  1   SRAM chip enable, active low
//  sram_wen     out  1   SRAM write enable, active low
//  sram_a       out  ADDR_WIDTH  SRAM address
//  sram_d       out  DATA_WIDTH  SRAM write data
//  sram_q       in   DATA_WIDTH  SRAM read data
// BEHAVIOUR
//  Reset: sram_cen=1, sram_wen=1, sram_a=0, sram_d=0; all gnt/rvalid=0;
//   io_lock_ack=0, cpu_stall=0, age counter=0, state=NORMAL.
//  Issue: reqs sampled at edge k; winner's addr/we/wdata registered to
//   sram_* with sram_cen=0, sram_wen=~we, and winner *_gnt=1 for cycle k+1.
//   No winner: sram_cen=1, sram_wen=1, a/d hold. One access per cycle max.
//  Read latency: SRAM samples at edge k+1; *_rvalid=1 in cycle k+2,
//   rdata=sram_q. Writes never raise rvalid.
//  Handshake: requester holds req/addr/we/wdata until gnt; it may present its
//   next request during the gnt cycle (back-to-back at full rate).
//  Priority (NORMAL): D > I > IO; if age==STARVE_LIMIT, IO wins once.
//   Age increments each cycle io_req=1 and IO not chosen, saturates at
//   STARVE_LIMIT, clears when IO granted or io_req=0.
//  FSM: NORMAL -io_lock-> DRAIN (no new grants; waits for the issued access
//   and its rvalid cycle to complete) -> LOCKED (io_lock_ack=1, only IO
//   granted) -!io_lock-> NORMAL next cycle. io_lock drop in DRAIN -> NORMAL.
//   cpu_stall=1 in DRAIN and LOCKED.
//  Simultaneous io_lock and D/I req in NORMAL: lock takes priority, no CPU
//   grant that edge. D/I reqs during LOCKED stay pending, served after unlock.
//  Reset mid-access: outputs return to reset values; in-flight rvalid dropped.
// STRUCTURE
//  sram_arb_pkg: requester IDs (REQ_IO/REQ_D/REQ_I), state encodings
//   (ST_NORMAL/ST_DRAIN/ST_LOCKED), default widths.
//  Sub-module sram_arb_age_ctr: saturating starvation counter with promote
//   flag. Top holds FSM, priority select, SRAM output regs, rvalid pipe.
// TESTING (bench with RA1SHD_IBM512X8 model)
//  D write 0x1A5 <- 0x3C, then D read 0x1A5 -> d_gnt 1 cycle after req,
//   d_rvalid 2 cycles after req, rdata=0x3C.
//  D and I req same cycle (D 0x020, I 0x021) -> d_gnt first, i_gnt next
//   cycle, rvalids in same order, no overlap.
//  D held busy 20 cycles, io_req read 0x000 -> io_gnt after exactly
//   STARVE_LIMIT=8 waiting cycles, D resumes next cycle.
//  io_lock during D read burst -> grants stop, last d_rvalid seen, then
//   io_lock_ack=1, cpu_stall=1; IO writes 0x00AB to 0x000/0x001 succeed;
//   d_req ignored until io_lock=0.
//  rst_n low during I read grant -> sram_cen=1 and i_rvalid=0 immediately,
//   no stray rvalid after release.
//  I-fetch sweep 0x020-0x02D back-to-back -> 14 grants in 14 cycles, data
//   matches preloaded program.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the single-port SRAM arbiter: requester IDs,
// lock FSM encodings and default widths.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 8;
    localparam int STARVE_DEF = 8;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_IO   = 2'd1,
        REQ_D    = 2'd2,
        REQ_I    = 2'd3
    } req_id_t;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_arb_age_ctr.sv
// Saturating count of cycles the IO port has waited unserved; promote is
// raised once the wait reaches LIMIT so IO can win one arbitration.
module sram_arb_age_ctr #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic io_req,
    input  logic io_win,
    output logic promote
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] age;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            age <= '0;
        else if (!io_req || io_win)
            age <= '0;
        else if (age != MAX)
            age <= age + 1'b1;
    end

    assign promote = (age == MAX);

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates IO, CPU data and CPU fetch onto one registered SRAM port, with
// an exclusive IO lock mode that stalls the CPU while IO owns the array.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_W_DEF,
    parameter int DATA_WIDTH   = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  io_lock,
    output logic                  io_lock_ack,
    output logic                  cpu_stall,
    input  logic                  io_req,
    input  logic                  d_req,
    input  logic                  i_req,
    input  logic                  io_we,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] io_addr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] io_wdata,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  io_gnt,
    output logic                  d_gnt,
    output logic                  i_gnt,
    output logic                  io_rvalid,
    output logic                  d_rvalid,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    arb_state_t state, state_nxt;
    req_id_t    win;
    logic       promote;

    sram_arb_age_ctr #(.LIMIT(STARVE_LIMIT)) u_age (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_req  (io_req),
        .io_win  (win == REQ_IO),
        .promote (promote)
    );

    // DRAIN may leave once nothing is granted this cycle: any earlier access
    // has its rvalid in this cycle or already behind it.
    always_comb begin
        state_nxt = state;
        win       = REQ_NONE;
        case (state)
            ST_NORMAL: begin
                if (io_lock)
                    state_nxt = ST_DRAIN;
                else if (io_req && promote)
                    win = REQ_IO;
                else if (d_req)
                    win = REQ_D;
                else if (i_req)
                    win = REQ_I;
                else if (io_req)
                    win = REQ_IO;
            end
            ST_DRAIN: begin
                if (!io_lock)
                    state_nxt = ST_NORMAL;
                else if (!(io_gnt || d_gnt || i_gnt))
                    state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (io_req)
                    win = REQ_IO;
                if (!io_lock)
                    state_nxt = ST_NORMAL;
            end
            default: state_nxt = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_NORMAL;
            sram_cen  <= 1'b1;
            sram_wen  <= 1'b1;
            sram_a    <= '0;
            sram_d    <= '0;
            io_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            i_gnt     <= 1'b0;
            io_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            i_rvalid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            io_gnt    <= (win == REQ_IO);
            d_gnt     <= (win == REQ_D);
            i_gnt     <= (win == REQ_I);
            // sram_wen high during a grant cycle marks that access as a read
            io_rvalid <= io_gnt & sram_wen;
            d_rvalid  <= d_gnt & sram_wen;
            i_rvalid  <= i_gnt;
            sram_cen  <= (win == REQ_NONE);
            case (win)
                REQ_IO: begin
                    sram_wen <= ~io_we;
                    sram_a   <= io_addr;
                    sram_d   <= io_wdata;
                end
                REQ_D: begin
                    sram_wen <= ~d_we;
                    sram_a   <= d_addr;
                    sram_d   <= d_wdata;
                end
                REQ_I: begin
                    sram_wen <= 1'b1;
                    sram_a   <= i_addr;
                end
                default: sram_wen <= 1'b1;
            endcase
        end
    end

    assign rdata       = sram_q;
    assign io_lock_ack = (state == ST_LOCKED);
    assign cpu_stall   = (state != ST_NORMAL);

endmodule
